ram_refresh_ctl: RTL and testbench
==================================

# ram_refresh_ctl

Refresh responder for the on-board DRAM. It consumes the `RefReq`/`RefUrg` pair produced by the E-clock refresh timer and executes one CAS-before-RAS refresh cycle per timer period. It prefers idle bus slots and holds off new RAM accesses only when the request becomes urgent. It sits between the counter block and the RAM access controller, which muxes `RefRAS`/`RefCAS` onto the DRAM strobes.

## Interface
Parameters:
- `CAS_SETUP`, default 1: cycles `RefCAS` is asserted before `RefRAS` (≥1).
- `RAS_WIDTH`, default 4: cycles both strobes are asserted (≥1).
- `PRECHARGE`, default 2: cycles both strobes are deasserted before a new RAM access may start (≥1).

Ports:
- `CLK`, in, 1: FSB clock. The block has one clock; reset is synchronous and active-high.
- `RES`, in, 1: synchronous active-high reset.
- `RefReq`, in, 1: refresh timer request, registered on `CLK`.
- `RefUrg`, in, 1: refresh timer urgent flag, registered on `CLK`.
- `RAMBusy`, in, 1: RAM controller is mid-access.
- `BACT`, in, 1: CPU bus cycle is active.
- `RefHold`, out, 1: RAM controller must not start a new access.
- `RefRAS`, out, 1: refresh RAS enable, active-high.
- `RefCAS`, out, 1: refresh CAS enable, active-high.
- `RefBusy`, out, 1: refresh FSM is not IDLE.
- `RefDone`, out, 1: one-cycle pulse when a refresh completes.
- `RefMiss`, out, 1: sticky flag; a refresh period was lost.

## Operation
- Edge detect: `RefReqr` holds the previous `RefReq`; reset value 0. A rising edge (`RefReq && !RefReqr`) marks a new refresh period.
- `Pend` flag:
  - Set on a rising edge.
  - Cleared on the `RefDone` cycle.
  - If a rising edge and `RefDone` coincide, `Pend` stays 1 and `RefMiss` is not set.
- `RefMiss` is set when a rising edge arrives while `Pend`=1 and `RefDone`=0. Only `RES` clears it.
- Start conditions, evaluated in IDLE:
  - Opportunistic start: `Pend && !RAMBusy && !BACT`.
  - Urgent start: `Pend && RefUrg && !RAMBusy`. This ignores `BACT`; the CPU cycle is stretched by the RAM controller because of `RefHold`.
- `RefHold` = `(Pend && RefUrg) || state!=IDLE`, registered. It prevents the RAM controller from launching an access in the same cycle a refresh starts.
- FSM states:
  - IDLE, on a start condition: go to CAS.
  - CAS: `RefCAS`=1 for `CAS_SETUP` cycles, then go to RAS.
  - RAS: `RefCAS`=`RefRAS`=1 for `RAS_WIDTH` cycles, then go to PRE.
  - PRE: both strobes 0 for `PRECHARGE` cycles. `RefDone`=1 on the last PRE cycle, then go to IDLE.
- Once a refresh starts it always completes; `RAMBusy`, `BACT` and `RefUrg` are ignored until IDLE.
- Reset mid-operation: the FSM returns to IDLE immediately, strobes drop in the same cycle as the `RES` edge, and `Pend` is cleared.
- Reset values: `RefHold`, `RefRAS`, `RefCAS`, `RefBusy`, `RefDone` and `RefMiss` are all 0.

## Timing
- All outputs are registered.
- Latency:
  - Start condition true at edge N → `RefCAS` high after edge N+1.
  - `RefRAS` rises `CAS_SETUP` cycles after `RefCAS`.
- Total refresh length is `CAS_SETUP+RAS_WIDTH+PRECHARGE` cycles; the default is 7.
- Phase counter: width `$clog2(max(params))+1`. It loads `param-1` on state entry and decrements to 0, with no wrap. Parameter value 1 gives a one-cycle state.
- `RefHold` rises one cycle after `Pend && RefUrg`. It falls on the cycle after `RefDone` unless `Pend && RefUrg` is still true.
- Back-to-back periods: the next IDLE start is allowed on the cycle after `RefDone`.

## Structure
- Shared package holds the state enum (`RS_IDLE`, `RS_CAS`, `RS_RAS`, `RS_PRE`) and the default timing constants, so the RAM controller can size its hold-off.
- Single module with no sub-modules. The edge detector and pending/miss logic are inline.

## Test plan
- Opportunistic refresh:
  - Stimulus: `RefReq` 0→1, `RAMBusy`=`BACT`=0, defaults.
  - Response: `RefCAS` rises 2 cycles after the edge, `RefRAS` 1 cycle later for 4 cycles, `RefDone` pulse at cycle 7 of the refresh, `Pend`=0.
- Deferred by bus:
  - Stimulus: `Pend`=1, `BACT`=1 held for 20 cycles, `RefUrg`=0.
  - Response: no strobes and `RefHold`=0; refresh starts 1 cycle after `BACT` drops.
- Urgent:
  - Stimulus: `Pend`=1, `BACT`=1, `RefUrg`→1, `RAMBusy`=1 for 3 more cycles.
  - Response: `RefHold` high 1 cycle after `RefUrg`; `RefCAS` rises 1 cycle after `RAMBusy` falls, even though `BACT`=1.
- Miss:
  - Stimulus: two `RefReq` rising edges with `BACT` held high and `RefUrg`=0.
  - Response: `RefMiss`=1 after the second edge and stays set until `RES`.
- Coincident edge:
  - Stimulus: `RefReq` rising edge on the `RefDone` cycle.
  - Response: `Pend` remains 1, `RefMiss`=0, and a second refresh follows.
- Reset mid-RAS:
  - Stimulus: assert `RES` for 1 cycle during RAS.
  - Response: `RefRAS`, `RefCAS`, `RefBusy` and `RefHold` are 0 the next cycle, `Pend`=0, and no `RefDone`.

Source files
------------

// File: rtl/ram_refresh_ctl_pkg.sv
// Shared definitions for the DRAM refresh responder: FSM state encoding and
// default strobe timing, so the RAM controller can size its hold-off window.
package ram_refresh_ctl_pkg;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_CAS  = 2'd1,
        RS_RAS  = 2'd2,
        RS_PRE  = 2'd3
    } ref_state_e;

    localparam int REF_CAS_SETUP = 1;
    localparam int REF_RAS_WIDTH = 4;
    localparam int REF_PRECHARGE = 2;
    localparam int REF_CYCLES    = REF_CAS_SETUP + REF_RAS_WIDTH + REF_PRECHARGE;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ram_refresh_ctl.sv
// CAS-before-RAS refresh responder: takes the refresh timer request/urgent pair
// and runs one refresh per period, preferring idle bus slots.
module ram_refresh_ctl
    import ram_refresh_ctl_pkg::*;
#(
    parameter int CAS_SETUP = REF_CAS_SETUP,
    parameter int RAS_WIDTH = REF_RAS_WIDTH,
    parameter int PRECHARGE = REF_PRECHARGE
) (
    input  logic CLK,
    input  logic RES,
    input  logic RefReq,
    input  logic RefUrg,
    input  logic RAMBusy,
    input  logic BACT,
    output logic RefHold,
    output logic RefRAS,
    output logic RefCAS,
    output logic RefBusy,
    output logic RefDone,
    output logic RefMiss
);

    localparam int CW = $clog2(max3(CAS_SETUP, RAS_WIDTH, PRECHARGE)) + 1;
    localparam logic [CW-1:0] CAS_LD = CW'(CAS_SETUP - 1);
    localparam logic [CW-1:0] RAS_LD = CW'(RAS_WIDTH - 1);
    localparam logic [CW-1:0] PRE_LD = CW'(PRECHARGE - 1);

    ref_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q;
    logic          pend_q, pend_d;
    logic          miss_d;
    logic          rise, last_pre, start;
    logic          hold_d, ras_d, cas_d, busy_d, done_d;

    assign rise     = RefReq && !req_q;
    assign last_pre = (state_q == RS_PRE) && (cnt_q == '0);
    // Urgency lets the refresh pre-empt an active CPU cycle, never a RAM access.
    assign start    = pend_q && !RAMBusy && (!BACT || RefUrg);
    assign pend_d   = rise || (pend_q && !last_pre);
    assign miss_d   = RefMiss || (rise && pend_q && !last_pre);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= RS_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            pend_q  <= 1'b0;
            RefMiss <= 1'b0;
            RefHold <= 1'b0;
            RefRAS  <= 1'b0;
            RefCAS  <= 1'b0;
            RefBusy <= 1'b0;
            RefDone <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= RefReq;
            pend_q  <= pend_d;
            RefMiss <= miss_d;
            RefHold <= hold_d;
            RefRAS  <= ras_d;
            RefCAS  <= cas_d;
            RefBusy <= busy_d;
            RefDone <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RS_IDLE: begin
                if (start) begin
                    state_d = RS_CAS;
                    cnt_d   = CAS_LD;
                end
            end
            RS_CAS: begin
                if (cnt_q == '0) begin
                    state_d = RS_RAS;
                    cnt_d   = RAS_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RS_RAS: begin
                if (cnt_q == '0) begin
                    state_d = RS_PRE;
                    cnt_d   = PRE_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RS_PRE: begin
                if (cnt_q == '0) begin
                    state_d = RS_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = RS_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes decode the current state and are registered one cycle later.
    always_comb begin
        busy_d = (state_q != RS_IDLE);
        cas_d  = (state_q == RS_CAS) || (state_q == RS_RAS);
        ras_d  = (state_q == RS_RAS);
        done_d = last_pre;
        hold_d = (pend_q && RefUrg) || busy_d;
    end

endmodule

// File: tb/tb_ram_refresh_ctl.sv
// Bench for ram_refresh_ctl: directed scenarios and random traffic, each cycle
// compared against a refresh-phase reference model.
module tb_ram_refresh_ctl;

    localparam int CS = 1;
    localparam int RW = 4;
    localparam int PR = 2;
    localparam int L  = CS + RW + PR;

    logic CLK, RES, RefReq, RefUrg, RAMBusy, BACT;
    logic RefHold, RefRAS, RefCAS, RefBusy, RefDone, RefMiss;
    logic [5:0] obs;
    logic [5:0] exp_v;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pending/miss flags and the cycle count since refresh start.
    bit m_prev, m_pend, m_miss;
    int m_k;

    ram_refresh_ctl #(.CAS_SETUP(CS), .RAS_WIDTH(RW), .PRECHARGE(PR)) dut (
        .CLK(CLK), .RES(RES), .RefReq(RefReq), .RefUrg(RefUrg),
        .RAMBusy(RAMBusy), .BACT(BACT), .RefHold(RefHold), .RefRAS(RefRAS),
        .RefCAS(RefCAS), .RefBusy(RefBusy), .RefDone(RefDone), .RefMiss(RefMiss)
    );

    assign obs = {RefHold, RefRAS, RefCAS, RefBusy, RefDone, RefMiss};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        bit rise, done_ev, start;
        if (RES) begin
            m_prev = 0; m_pend = 0; m_miss = 0; m_k = 0;
            exp_v  = 6'b0;
        end else begin
            rise    = RefReq && !m_prev;
            done_ev = (m_k == L);
            start   = (m_k == 0) && m_pend && !RAMBusy && (!BACT || RefUrg);
            if (rise && m_pend && !done_ev) m_miss = 1;
            exp_v = {(m_k > 0) || (m_pend && RefUrg),
                     (m_k > CS) && (m_k <= CS + RW),
                     (m_k >= 1) && (m_k <= CS + RW),
                     (m_k > 0),
                     done_ev,
                     m_miss};
            if (start) m_k = 1;
            else if (m_k == L) m_k = 0;
            else if (m_k > 0) m_k = m_k + 1;
            if (rise) m_pend = 1;
            else if (done_ev) m_pend = 0;
            m_prev = RefReq;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RES = 1; RefReq = 0; RefUrg = 0; RAMBusy = 0; BACT = 0;
        step();
        step();
        RES = 0;
    endtask

    task automatic test_reset();
        RES = 1; RefReq = 1; RefUrg = 1; RAMBusy = 0; BACT = 0;
        step();
        step();
        n_total++;
        if (obs !== 6'b0) $display("FAIL reset_values got %b want 000000", obs);
        else n_pass++;
        RES = 0; RefReq = 0; RefUrg = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (obs !== exp_v) $display("FAIL reset_idle cyc%0d got %b want %b", i, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_opportunistic();
        int first_cas, first_ras, done_at, ras_cnt;
        first_cas = -1; first_ras = -1; done_at = -1; ras_cnt = 0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            RefReq = (i < 3);
            step();
            if (RefCAS && first_cas < 0) first_cas = i;
            if (RefRAS && first_ras < 0) first_ras = i;
            if (RefRAS) ras_cnt++;
            if (RefDone && done_at < 0) done_at = i;
            n_total++;
            if (obs !== exp_v) $display("FAIL opp cyc%0d got %b want %b", i, obs, exp_v);
            else n_pass++;
        end
        n_total++;
        if (first_cas !== 2) $display("FAIL opp_cas_latency got %0d want 2", first_cas);
        else n_pass++;
        n_total++;
        if (first_ras !== 3 || ras_cnt !== 4)
            $display("FAIL opp_ras got start %0d len %0d want 3 4", first_ras, ras_cnt);
        else n_pass++;
        n_total++;
        if (done_at !== 8) $display("FAIL opp_done got %0d want 8", done_at);
        else n_pass++;
    endtask

    task automatic test_deferred();
        int first_cas;
        bit leaked;
        first_cas = -1; leaked = 0;
        do_reset();
        BACT = 1;
        for (int i = 0; i < 20; i++) begin
            RefReq = (i < 2);
            step();
            if (RefCAS || RefHold || RefRAS) leaked = 1;
            n_total++;
            if (obs !== exp_v) $display("FAIL defer cyc%0d got %b want %b", i, obs, exp_v);
            else n_pass++;
        end
        n_total++;
        if (leaked) $display("FAIL defer_quiet got strobe/hold activity want none");
        else n_pass++;
        BACT = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (RefCAS && first_cas < 0) first_cas = j;
            n_total++;
            if (obs !== exp_v) $display("FAIL defer_run cyc%0d got %b want %b", j, obs, exp_v);
            else n_pass++;
        end
        n_total++;
        if (first_cas !== 1) $display("FAIL defer_start got %0d want 1", first_cas);
        else n_pass++;
    endtask

    task automatic test_urgent();
        int first_cas;
        first_cas = -1;
        do_reset();
        BACT = 1;
        RefReq = 1; step();
        RefReq = 0; step();
        RefUrg = 1; RAMBusy = 1;
        step();
        n_total++;
        if (RefHold !== 1'b1) $display("FAIL urg_hold got %b want 1", RefHold);
        else n_pass++;
        step();
        step();
        RAMBusy = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (RefCAS && first_cas < 0) first_cas = j;
            n_total++;
            if (obs !== exp_v) $display("FAIL urg cyc%0d got %b want %b", j, obs, exp_v);
            else n_pass++;
        end
        n_total++;
        if (first_cas !== 1) $display("FAIL urg_cas got %0d want 1", first_cas);
        else n_pass++;
        RefUrg = 0;
    endtask

    task automatic test_miss();
        do_reset();
        BACT = 1;
        for (int i = 0; i < 16; i++) begin
            RefReq = (i < 2) || (i >= 5 && i < 7);
            step();
            n_total++;
            if (obs !== exp_v) $display("FAIL miss cyc%0d got %b want %b", i, obs, exp_v);
            else n_pass++;
            if (i >= 5) begin
                n_total++;
                if (RefMiss !== 1'b1) $display("FAIL miss_sticky cyc%0d got %b want 1", i, RefMiss);
                else n_pass++;
            end
        end
        RES = 1; step(); RES = 0;
        n_total++;
        if (RefMiss !== 1'b0) $display("FAIL miss_clear got %b want 0", RefMiss);
        else n_pass++;
        BACT = 0;
    endtask

    task automatic test_coincident();
        int guard;
        bit second;
        guard = 0; second = 0;
        do_reset();
        RefReq = 1; step();
        RefReq = 0;
        while (m_k != L && guard < 20) begin
            step();
            guard++;
        end
        n_total++;
        if (guard >= 20) $display("FAIL coinc_reach got timeout want last precharge");
        else n_pass++;
        RefReq = 1;
        step();
        n_total++;
        if (RefDone !== 1'b1 || RefMiss !== 1'b0)
            $display("FAIL coinc_edge got done %b miss %b want 1 0", RefDone, RefMiss);
        else n_pass++;
        RefReq = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (RefCAS) second = 1;
            n_total++;
            if (obs !== exp_v) $display("FAIL coinc cyc%0d got %b want %b", j, obs, exp_v);
            else n_pass++;
        end
        n_total++;
        if (!second) $display("FAIL coinc_second got no refresh want refresh");
        else n_pass++;
    endtask

    task automatic test_reset_mid_ras();
        int guard;
        bit saw_done;
        guard = 0; saw_done = 0;
        do_reset();
        RefReq = 1; step();
        RefReq = 0;
        while (!RefRAS && guard < 10) begin
            step();
            guard++;
        end
        n_total++;
        if (!RefRAS) $display("FAIL rst_ras_reach got timeout want RefRAS");
        else n_pass++;
        RES = 1; step(); RES = 0;
        n_total++;
        if (obs !== 6'b0) $display("FAIL rst_ras_drop got %b want 000000", obs);
        else n_pass++;
        for (int j = 0; j < 10; j++) begin
            step();
            if (RefDone || RefCAS) saw_done = 1;
            n_total++;
            if (obs !== exp_v) $display("FAIL rst_ras cyc%0d got %b want %b", j, obs, exp_v);
            else n_pass++;
        end
        n_total++;
        if (saw_done) $display("FAIL rst_ras_nodone got activity want none");
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) RefReq = ~RefReq;
            BACT    = ($urandom_range(0, 1) == 1);
            RAMBusy = ($urandom_range(0, 9) < 3);
            RefUrg  = ($urandom_range(0, 9) < 2);
            RES     = ($urandom_range(0, 299) == 0);
            step();
            n_total++;
            if (obs !== exp_v) begin
                if (errs < 20) $display("FAIL random cyc%0d got %b want %b", i, obs, exp_v);
                errs++;
            end else n_pass++;
        end
        RES = 0;
    endtask

    initial begin
        RES = 1; RefReq = 0; RefUrg = 0; RAMBusy = 0; BACT = 0;
        m_prev = 0; m_pend = 0; m_miss = 0; m_k = 0; exp_v = 6'b0;
        test_reset();
        test_opportunistic();
        test_deferred();
        test_urgent();
        test_miss();
        test_coincident();
        test_reset_mid_ras();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
